axi_rd_engine: RTL
==================

# axi_rd_engine

AXI read-channel master for the systolic-array data path. It consumes the burst request stream produced by the address generator (`req_*`) and issues AR transactions. It collects R beats and forwards them as a registered, back-pressurable word stream to the input buffer / tile loader. It tracks outstanding bursts, checks beat counts and response codes, and flags completion of the command's final burst.

## Interface
Parameters:
- `ADDR_W`, default `AXI_ADDR_WIDTH`: address width.
- `DATA_W`, default `AXI_DATA_WIDTH`: data width. V1 requires 32; simulation issues `$fatal` otherwise.
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-incomplete bursts. Power of 2, range 2..16.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1; `req_ready` out 1; `req_addr` in ADDR_W; `req_len` in 8 (beats-1); `req_last` in 1: burst request stream.
- `m_arvalid` out 1; `m_arready` in 1; `m_araddr` out ADDR_W; `m_arlen` out 8; `m_arsize` out 3; `m_arburst` out 2: AXI AR channel.
- `m_rvalid` in 1; `m_rready` out 1; `m_rdata` in DATA_W; `m_rresp` in 2; `m_rlast` in 1: AXI R channel.
- `out_valid` out 1; `out_ready` in 1; `out_data` out DATA_W; `out_last` out 1: data stream. `out_last` marks the final beat of a burst tagged `req_last`.
- `done` out 1: one-cycle pulse after the `out_last` beat is accepted.
- `err` out 1: sticky error flag.
- `err_clr` in 1: clears `err`.

## Operation
- Constant outputs: `m_arsize`=3'b010 and `m_arburst`=2'b01 (INCR).
- Request acceptance: `req_ready` = !`m_arvalid` && (`os_cnt` < MAX_OUTSTANDING). On req fire:
  - latch `req_addr` into `m_araddr` and `req_len` into `m_arlen`;
  - set `m_arvalid`;
  - push {`req_last`, `req_len`} into the tracking FIFO (depth MAX_OUTSTANDING).
- AR stays stable until `m_arready`. On AR fire, `m_arvalid` clears.
- `os_cnt` width is clog2(MAX_OUTSTANDING)+1.
  - It increments on req fire and decrements on burst completion.
  - If both happen in the same cycle, it is unchanged.
- R acceptance: `m_rready` = (FIFO non-empty) && (!`out_valid` || `out_ready`). If no burst is tracked, `m_rready`=0.
- Beat counter `beat_cnt` (8 bit) counts accepted R beats of the FIFO head burst.
  - Expected last beat: `beat_cnt` == head.len.
  - On the expected last beat: pop the FIFO, reset `beat_cnt` to 0, decrement `os_cnt`.
  - Burst framing follows the expected count only; `m_rlast` is checked, never trusted.
- Output register: on R fire, load `out_data`=`m_rdata` and `out_last`=(expected last beat && head.last), and set `out_valid`. `out_valid` clears when `out_ready` is high and no new beat is loaded that cycle.
- `done` pulses in the cycle after `out_valid && out_ready && out_last`.
- Error detection, per accepted beat. Each case sets `err`, and the data is still forwarded:
  - `m_rresp` != 2'b00;
  - `m_rlast`=1 when not at the expected last beat;
  - `m_rlast`=0 at the expected last beat.
- `err_clr` clears `err`. If a set and `err_clr` occur in the same cycle, the set wins.

## Timing
- Reset values: `req_ready`=0 while in reset and 1 after reset (FIFO empty, `os_cnt`=0). `m_arvalid`=0, `m_araddr`=0, `m_arlen`=0, `m_rready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, `err`=0.
- Req fire at cycle N: `m_arvalid`=1 from N+1. Minimum AR issue interval is 2 cycles.
- R fire at cycle M: `out_valid`=1 at M+1. With `out_ready` held high, throughput is 1 beat/cycle.
- R beats may arrive in the cycle after AR fire. The FIFO entry exists from the req-fire cycle.
- Full: `os_cnt`==MAX_OUTSTANDING forces `req_ready`=0. `req_ready` re-rises in the cycle after the completing beat.
- FIFO pointers wrap modulo MAX_OUTSTANDING; full and empty are distinguished by `os_cnt`.
- Reset mid-operation: all state is cleared immediately and in-flight AXI transactions are abandoned. Quiescing the bus before reset is the integrator's responsibility.

## Test plan
- Single burst, `req_addr`=0x1000, `req_len`=15, `req_last`=1, slave returns 16 OKAY beats with `m_rlast` on beat 16:
  - `m_araddr`=0x1000, `m_arlen`=15;
  - 16 `out_valid` beats, `out_last` only on beat 16;
  - `done` pulses once, `err`=0.
- Three requests (len 15, 15, 3; last on the third), `out_ready`=1: 36 output beats in order, `out_last` only on beat 36, one `done`, `os_cnt` returns to 0.
- `out_ready` toggling 1/0 every cycle during a 16-beat burst: `m_rready` tracks the output stall, no beat is dropped or duplicated, and data order is preserved.
- MAX_OUTSTANDING=4, `m_arready`=1, R withheld:
  - after 4 req fires, `req_ready`=0;
  - after the first burst completes, `req_ready`=1 on the next cycle.
- Beat 3 returns `m_rresp`=2'b10, and a later burst with `req_len`=7 asserts `m_rlast` on beat 5:
  - `err`=1 after beat 3;
  - burst framing continues to 8 beats;
  - `err_clr` asserted alone clears `err`; asserted in the same cycle as a new error, `err` stays 1.
- Assert `rstn` low mid-burst: all outputs take their reset values asynchronously. After release, a fresh single burst completes normally.

Source files
------------

// File: rtl/axi_rd_engine.sv
// AXI read-channel master: turns burst requests into AR transactions and
// forwards R beats as a registered, back-pressurable word stream.
module axi_rd_engine #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic              req_last,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  if (DATA_W != 32) begin : g_bad_data_w
    $fatal(1, "axi_rd_engine: DATA_W must be 32");
  end
  if ((MAX_OUTSTANDING < 2) || (MAX_OUTSTANDING > 16) ||
      ((1 << PTR_W) != MAX_OUTSTANDING)) begin : g_bad_max_os
    $fatal(1, "axi_rd_engine: MAX_OUTSTANDING must be a power of 2 in 2..16");
  end

  logic              r_ready_en;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [7:0]        r_fifo_len  [MAX_OUTSTANDING];
  logic              r_fifo_last [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_os_cnt;
  logic [7:0]        r_beat_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_done;
  logic              r_err;

  logic              w_req_fire;
  logic              w_r_fire;
  logic              w_exp_last;
  logic              w_pop;
  logic              w_beat_err;

  assign req_ready  = r_ready_en && !r_arvalid && (r_os_cnt < MAX_CNT);
  assign m_rready   = (r_os_cnt != '0) && (!r_out_valid || out_ready);
  assign w_req_fire = req_valid && req_ready;
  assign w_r_fire   = m_rvalid && m_rready;
  assign w_exp_last = (r_beat_cnt == r_fifo_len[r_rd_ptr]);
  assign w_pop      = w_r_fire && w_exp_last;
  // Framing follows the tracked length; m_rlast only feeds the error check.
  assign w_beat_err = w_r_fire && ((m_rresp != 2'b00) || (m_rlast != w_exp_last));

  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;

  // Keeps req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ready_en <= 1'b0;
    else       r_ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else if (w_req_fire) begin
      r_arvalid <= 1'b1;
      r_araddr  <= req_addr;
      r_arlen   <= req_len;
    end else if (m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  // Tracking FIFO; occupancy equals r_os_cnt, which also separates full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo_len[i]  <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_os_cnt   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_req_fire) begin
        r_fifo_len[r_wr_ptr]  <= req_len;
        r_fifo_last[r_wr_ptr] <= req_last;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_req_fire, w_pop})
        2'b10:   r_os_cnt <= r_os_cnt + 1'b1;
        2'b01:   r_os_cnt <= r_os_cnt - 1'b1;
        default: r_os_cnt <= r_os_cnt;
      endcase
      if (w_r_fire) r_beat_cnt <= w_exp_last ? 8'd0 : r_beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_r_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= m_rdata;
        r_out_last  <= w_exp_last && r_fifo_last[r_rd_ptr];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_done <= r_out_valid && out_ready && r_out_last;
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_err <= 1'b0;
    else if (w_beat_err) r_err <= 1'b1;
    else if (err_clr)    r_err <= 1'b0;
  end

endmodule
